// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: interrupts are taken at instruction boundaries.
// Each entry pushes the return PC onto a small shadow stack and vectors to the ISR; RETI pops it back.
module int_sequencer #(
  parameter int pcWidth   = 8,
  parameter int nestDepth = 2
) (
  input  logic                               clk,
  input  logic                               clr,
  input  logic                               intPending,
  input  logic [pcWidth-1:0]                 isrAddr,
  input  logic                               instrDone,
  input  logic [pcWidth-1:0]                 pc,
  input  logic                               retiReq,
  input  logic                               globalEn,
  output logic                               ldIntReg,
  output logic                               clrIntReg,
  output logic                               clrPend,
  output logic                               intDisable,
  output logic                               ldPc,
  output logic [pcWidth-1:0]                 pcOut,
  output logic                               stall,
  output logic                               inIsr,
  output logic [$clog2(nestDepth+1)-1:0]     depth,
  output logic                               retErr
);

  localparam int DW = $clog2(nestDepth + 1);
  // The stack is sized to the full index range so a depth-wide index never needs truncating.
  localparam int SN = 1 << DW;

  typedef enum logic [2:0] {FLUSH, RUN, SAVE, VECTOR, RESTORE} state_t;

  state_t             state_reg, state_next;
  logic [DW-1:0]      depth_reg;
  logic               ret_err_reg;
  logic [pcWidth-1:0] stack_mem [SN];
  logic [DW-1:0]      top_idx;
  logic               at_limit;
  logic               push;
  logic               reti_underflow;

  assign top_idx  = depth_reg - DW'(1);
  assign at_limit = (depth_reg == DW'(nestDepth));
  assign depth    = depth_reg;
  assign inIsr    = (depth_reg != '0);
  assign retErr   = ret_err_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg   <= FLUSH;
      depth_reg   <= '0;
      ret_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ret_err_reg <= reti_underflow;
      if (state_reg == SAVE)
        depth_reg <= depth_reg + DW'(1);
      else if (state_reg == RESTORE)
        depth_reg <= depth_reg - DW'(1);
    end
  end

  // Return addresses need no reset; depth alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      stack_mem[depth_reg] <= pc;
  end

  always_comb begin
    state_next     = state_reg;
    ldIntReg       = 1'b0;
    clrIntReg      = 1'b0;
    clrPend        = 1'b0;
    intDisable     = 1'b1;
    ldPc           = 1'b0;
    pcOut          = '0;
    stall          = 1'b1;
    push           = 1'b0;
    reti_underflow = 1'b0;
    case (state_reg)
      FLUSH: begin
        clrIntReg  = 1'b1;
        clrPend    = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        ldIntReg   = 1'b1;
        stall      = 1'b0;
        intDisable = ~globalEn | at_limit;
        // RETI wins over a simultaneous interrupt; a stray RETI retires as a NOP.
        if (instrDone && retiReq) begin
          if (depth_reg != '0)
            state_next = RESTORE;
          else
            reti_underflow = 1'b1;
        end else if (instrDone && intPending && !intDisable) begin
          push       = 1'b1;
          state_next = SAVE;
        end
      end
      SAVE: begin
        state_next = VECTOR;
      end
      VECTOR: begin
        ldPc       = 1'b1;
        pcOut      = isrAddr;
        clrPend    = 1'b1;
        clrIntReg  = 1'b1;
        state_next = RUN;
      end
      RESTORE: begin
        ldPc       = 1'b1;
        pcOut      = stack_mem[top_idx];
        state_next = RUN;
      end
      default: begin
        state_next = FLUSH;
      end
    endcase
  end

endmodule
